// File: rtl/tt_um_count_seq.sv
// tt_um_count_seq: command-driven prescaled counter sequencer; COUNT_SEQ_AUTORELOAD_EN selects free-running reload mode
module tt_um_count_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] LOAD_START = 2'b00;
  localparam logic [1:0] LOAD_LIMIT = 2'b01;
  localparam logic [1:0] GO         = 2'b10;
  localparam logic [1:0] LOAD_DIV   = 2'b11;
  logic [7:0] count, start, limit, div, pre;
  logic [1:0] state;
  logic       done, tick;
  logic       cmd_valid, stop, cmd_ready, busy;
  logic [1:0] cmd;
  logic       unused;
  assign cmd_valid = uio_in[0];
  assign cmd       = uio_in[2:1];
  assign stop      = uio_in[3];
  assign unused    = ^{ena, uio_in[7:4]};
  assign busy      = state == RUN;
  assign cmd_ready = !busy;
  assign uo_out    = count;
  assign uio_out   = {tick, done, busy, cmd_ready, 4'b0000};
  assign uio_oe    = 8'hF0;
  // command decode in IDLE/DONE, prescaled stepping and abort in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'h00;
      start <= 8'h00;
      limit <= 8'hFF;
      div   <= 8'h00;
      pre   <= 8'h00;
      state <= IDLE;
      done  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
      done <= 1'b0;
`endif
      if (busy) begin
        if (stop) begin
          state <= IDLE;
          pre   <= 8'h00;
        end else if (pre == div) begin
          pre <= 8'h00;
          if (count == limit) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
            count <= start;
            tick  <= 1'b1;
            done  <= 1'b1;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            count <= count + 8'd1;
            tick  <= 1'b1;
          end
        end else begin
          pre <= pre + 8'd1;
        end
      end else if (cmd_valid) begin
        done <= 1'b0;
        case (cmd)
          LOAD_START: begin
            start <= ui_in;
            state <= IDLE;
          end
          LOAD_LIMIT: begin
            limit <= ui_in;
            state <= IDLE;
          end
          LOAD_DIV: begin
            div   <= ui_in;
            state <= IDLE;
          end
          GO: begin
            count <= start;
            pre   <= 8'h00;
            state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tt_um_count_seq.sv
// tb_tt_um_count_seq: directed checks of load/go/stop/done behaviour of tt_um_count_seq
module tb_tt_um_count_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       cv = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       stop = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;
  assign uio_in = {4'b0000, stop, cmd, cv};
  always #5 clk = ~clk;
  tt_um_count_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] c, input logic [7:0] v);
    ui_in = v;
    cmd = c;
    cv = 1'b1;
    step();
    cv = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h10);
    check("rst_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    step();
    check("idle_uio_out", uio_out, 8'h10);
`ifdef COUNT_SEQ_AUTORELOAD_EN
    issue(2'b00, 8'h00);
    issue(2'b01, 8'h02);
    issue(2'b11, 8'h00);
    issue(2'b10, 8'h00);
    check("ar_go_uo", uo_out, 8'h00);
    for (int e = 1; e <= 7; e++) begin
      step();
      check("ar_uo", uo_out, e % 3);
      check("ar_tick", uio_out[7], 1'b1);
      check("ar_done", uio_out[6], (e % 3) == 0);
      check("ar_busy", uio_out[5], 1'b1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ar_stop_busy", uio_out[5], 1'b0);
`else
    // limit keeps its reset value 0xFF
    issue(2'b00, 8'hFD);
    issue(2'b10, 8'h00);
    step();
    step();
    check("rstlim_uo", uo_out, 8'hFF);
    step();
    check("rstlim_done", uio_out[6], 1'b1);
    // basic run, div=0
    issue(2'b00, 8'h10);
    issue(2'b01, 8'h13);
    issue(2'b11, 8'h00);
    issue(2'b10, 8'h00);
    check("t1_go_uo", uo_out, 8'h10);
    check("t1_go_busy", uio_out[5], 1'b1);
    check("t1_go_done", uio_out[6], 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t1_uo", uo_out, 8'h10 + k);
      check("t1_tick", uio_out[7], 1'b1);
      check("t1_ready", uio_out[4], 1'b0);
    end
    step();
    check("t1_done_uio", uio_out, 8'h50);
    check("t1_done_uo", uo_out, 8'h13);
    step();
    check("t1_done_sticky", uio_out[6], 1'b1);
    // wrap through 0xFF, div=1
    issue(2'b00, 8'hFE);
    issue(2'b01, 8'h01);
    issue(2'b11, 8'h01);
    check("t2_load_clears_done", uio_out[6], 1'b0);
    issue(2'b10, 8'h00);
    check("t2_go_uo", uo_out, 8'hFE);
    for (int e = 1; e <= 8; e++) begin
      step();
      check("t2_uo", uo_out, e < 8 ? 8'(8'hFE + e / 2) : 8'h01);
      check("t2_tick", uio_out[7], (e % 2 == 0) && (e < 8));
      check("t2_done", uio_out[6], e == 8);
    end
    // stop abort, div=3; a load during RUN is dropped
    issue(2'b11, 8'h03);
    issue(2'b10, 8'h00);
    step();
    issue(2'b00, 8'h77);
    check("t3_run_busy", uio_out[5], 1'b1);
    check("t3_run_ready", uio_out[4], 1'b0);
    step();
    step();
    check("t3_inc_uo", uo_out, 8'hFF);
    check("t3_inc_tick", uio_out[7], 1'b1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_stop_uio", uio_out, 8'h10);
    check("t3_stop_uo", uo_out, 8'hFF);
    step();
    check("t3_idle_hold", uo_out, 8'hFF);
    issue(2'b10, 8'h00);
    check("t3_start_kept", uo_out, 8'hFE);
    stop = 1'b1;
    step();
    stop = 1'b0;
    // start == limit, div=2
    issue(2'b00, 8'h55);
    issue(2'b01, 8'h55);
    issue(2'b11, 8'h02);
    issue(2'b10, 8'h00);
    check("t4_go_uo", uo_out, 8'h55);
    for (int e = 1; e <= 2; e++) begin
      step();
      check("t4_wait", uio_out, 8'h20);
    end
    step();
    check("t4_done", uio_out, 8'h50);
    check("t4_uo", uo_out, 8'h55);
    issue(2'b00, 8'h20);
    check("t4_clear", uio_out, 8'h10);
    check("t4_count_kept", uo_out, 8'h55);
    // async reset mid-RUN
    issue(2'b10, 8'h00);
    check("t5_go_uo", uo_out, 8'h20);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_uo", uo_out, 8'h00);
    check("t5_rst_uio", uio_out, 8'h10);
    step();
    rst_n = 1'b1;
    step();
    check("t5_after_rst", uio_out, 8'h10);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
